// File: rtl/riscv_mem_pkg.sv
// Shared size codes, FSM encoding and request record for the RISC-V memory controller.
package riscv_mem_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  by;
        logic [31:0] wdata;
        logic        wr;
    } mem_req_t;

    // Size code 3 behaves as a word access.
    function automatic logic [2:0] size_bytes(input logic [1:0] by);
        case (by)
            MEM_B:   return 3'd1;
            MEM_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic is_split(input logic [1:0] off, input logic [1:0] by);
        return ({1'b0, off} + size_bytes(by)) > 3'd4;
    endfunction

endpackage

// File: rtl/riscv_mem_ctrl_if.sv
// CPU-side request/response bundle of the memory controller.
interface riscv_mem_ctrl_if;
    logic        mem_RE;
    logic        mem_WE;
    logic [1:0]  mem_by;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_done;
    logic        busy;
    logic        req_err;

    modport master (
        output mem_RE, mem_WE, mem_by, addr, wdata,
        input  rdata, mem_done, busy, req_err
    );

    modport slave (
        input  mem_RE, mem_WE, mem_by, addr, wdata,
        output rdata, mem_done, busy, req_err
    );
endinterface

// File: rtl/riscv_mem_lane.sv
// Byte-lane steering: store-data shift and byte enables per phase, load-data align and merge.
module riscv_mem_lane
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  by,
    input  logic        phase,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [31:0] rd_hi,
    output logic [3:0]  we,
    output logic [31:0] wd,
    output logic [31:0] rd
);

    logic [7:0]  size_mask;
    logic [7:0]  mask8;
    logic [63:0] data64;
    logic [31:0] keep;

    always_comb begin
        case (by)
            MEM_B:   begin size_mask = 8'h01; keep = 32'h0000_00FF; end
            MEM_H:   begin size_mask = 8'h03; keep = 32'h0000_FFFF; end
            default: begin size_mask = 8'h0F; keep = 32'hFFFF_FFFF; end
        endcase
        // Upper half of the 8-lane view belongs to the second word of a split access.
        mask8  = size_mask << off;
        data64 = {32'h0, wdata} << {off, 3'b000};
        we     = phase ? mask8[7:4] : mask8[3:0];
        wd     = phase ? data64[63:32] : data64[31:0];
        rd     = 32'({rd_hi, rd_lo} >> {off, 3'b000}) & keep;
    end

endmodule

// File: rtl/riscv_mem_ctrl.sv
// Load/store controller: one or two SRAM word accesses per request, split at word boundaries.
module riscv_mem_ctrl
    import riscv_mem_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    riscv_mem_ctrl_if.slave        cpu,
    output logic                   ram_en,
    output logic [3:0]             ram_we,
    output logic [29:0]            ram_addr,
    output logic [31:0]            ram_wdata,
    input  logic [31:0]            ram_rdata
);

    mem_state_t  state, state_nxt;
    mem_req_t    req_q;
    logic [31:0] cap_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        start, clash, split;
    logic [3:0]  lane_we;
    logic [31:0] lane_wd, lane_rd, rd_lo;

    assign start = (state == IDLE) && (cpu.mem_RE ^ cpu.mem_WE);
    assign clash = (state == IDLE) && cpu.mem_RE && cpu.mem_WE;
    assign split = is_split(req_q.addr[1:0], req_q.by);
    // Non-split loads take everything from the word arriving in DONE.
    assign rd_lo = split ? cap_q : ram_rdata;

    riscv_mem_lane u_lane (
        .off   (req_q.addr[1:0]),
        .by    (req_q.by),
        .phase (state == ACC1),
        .wdata (req_q.wdata),
        .rd_lo (rd_lo),
        .rd_hi (ram_rdata),
        .we    (lane_we),
        .wd    (lane_wd),
        .rd    (lane_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q   <= '0;
            cap_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= clash;
            if (start)
                req_q <= '{addr: cpu.addr, by: cpu.mem_by, wdata: cpu.wdata, wr: cpu.mem_WE};
            if (state == ACC1)
                cap_q <= ram_rdata;
            if (state == DONE && !req_q.wr)
                rdata_q <= lane_rd;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACC0;
            ACC0:    state_nxt = split ? ACC1 : DONE;
            ACC1:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are held quiet for the whole time reset is asserted.
    always_comb begin
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_addr     = '0;
        ram_wdata    = '0;
        cpu.mem_done = 1'b0;
        cpu.busy     = 1'b0;
        cpu.req_err  = 1'b0;
        cpu.rdata    = '0;
        if (!rst) begin
            cpu.busy    = (state != IDLE);
            cpu.req_err = err_q;
            cpu.rdata   = rdata_q;
            case (state)
                ACC0: begin
                    ram_en   = 1'b1;
                    ram_addr = req_q.addr[31:2];
                    if (req_q.wr) begin
                        ram_we    = lane_we;
                        ram_wdata = lane_wd;
                    end
                end
                ACC1: begin
                    ram_en   = 1'b1;
                    ram_addr = req_q.addr[31:2] + 30'd1;
                    if (req_q.wr) begin
                        ram_we    = lane_we;
                        ram_wdata = lane_wd;
                    end
                end
                DONE: begin
                    cpu.mem_done = 1'b1;
                    if (!req_q.wr) cpu.rdata = lane_rd;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_ctrl.sv
// Bench for riscv_mem_ctrl: directed vector table, corner sequences, random traffic vs byte-level model.
module tb_riscv_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;

    riscv_mem_ctrl_if bus();

    riscv_mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (bus),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM: word storage, 1-cycle read latency, read-before-write.
    logic [31:0] sram [bit [29:0]];
    logic [31:0] sw;
    always @(posedge clk) begin
        if (ram_en) begin
            sw = sram.exists(ram_addr) ? sram[ram_addr] : 32'h0;
            ram_rdata <= sw;
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) sw[8*i +: 8] = ram_wdata[8*i +: 8];
            sram[ram_addr] = sw;
        end
    end

    // Reference model: flat byte-addressed memory.
    logic [7:0] refb [bit [31:0]];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic int nbytes(input logic [1:0] by);
        return (by == 2'd0) ? 1 : (by == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a, input int n);
        logic [31:0] v = '0;
        logic [31:0] ba;
        for (int i = 0; i < n; i++) begin
            ba = a + 32'(i);
            if (refb.exists(ba)) v = v | (32'(refb[ba]) << (8 * i));
        end
        return v;
    endfunction

    task automatic ref_wr(input logic [31:0] a, input int n, input logic [31:0] d);
        for (int i = 0; i < n; i++) refb[a + 32'(i)] = d[8*i +: 8];
    endtask

    task automatic preload(input logic [29:0] wa, input logic [31:0] d);
        sram[wa] = d;
        ref_wr({wa, 2'b00}, 4, d);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one request issued in the current IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic do_access(input bit re, input bit we, input logic [1:0] by,
                             input logic [31:0] a, input logic [31:0] wd,
                             output int lat, output logic [31:0] rd,
                             output logic [29:0] a0, output logic [29:0] a1,
                             output logic [3:0] we0, output logic [3:0] we1,
                             output logic [31:0] wd0, output logic [31:0] wd1);
        bus.mem_RE = re; bus.mem_WE = we; bus.mem_by = by; bus.addr = a; bus.wdata = wd;
        tick();
        bus.mem_RE = 1'b0; bus.mem_WE = 1'b0;
        check("acc0_busy", 32'(bus.busy), 32'd1);
        check("acc0_en", 32'(ram_en), 32'd1);
        a0 = ram_addr; we0 = ram_we; wd0 = ram_wdata;
        a1 = '0; we1 = '0; wd1 = '0; rd = '0; lat = 0;
        for (int c = 2; c <= 5 && lat == 0; c++) begin
            tick();
            if (c == 2) begin a1 = ram_addr; we1 = ram_we; wd1 = ram_wdata; end
            if (bus.mem_done) begin lat = c; rd = bus.rdata; end
        end
        if (lat == 0) check("done_timeout", 32'd0, 32'd1);
        tick();
        check("idle_after_done", 32'(bus.busy), 32'd0);
        if (re) check("rdata_hold", bus.rdata, rd);
    endtask

    typedef struct {
        bit          wr;
        logic [1:0]  by;
        logic [31:0] a, wd;
        bit          pre;
        logic [29:0] pa0, pa1;
        logic [31:0] pd0, pd1;
        int          lat;
        logic [31:0] rd;
        logic [29:0] a0, a1;
        logic [3:0]  we0, we1;
        logic [31:0] wd0, wd1;
    } vec_t;

    vec_t vt [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] rd, wd0, wd1, exp, a, wd;
        logic [29:0] a0, a1;
        logic [3:0]  we0, we1;
        logic [1:0]  by;
        bit re, wr, saw_done;
        int n;

        vt[0] = '{1, 2'd2, 32'h100, 32'hDEADBEEF, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  2, 32'h0, 30'h40, 30'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0};
        vt[1] = '{0, 2'd2, 32'h100, 32'h0, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  2, 32'hDEADBEEF, 30'h40, 30'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vt[2] = '{0, 2'd0, 32'h103, 32'h0, 1, 30'h40, 30'h40, 32'h11223344, 32'h11223344,
                  2, 32'h11, 30'h40, 30'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vt[3] = '{1, 2'd1, 32'h203, 32'hABCD, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  3, 32'h0, 30'h80, 30'h81, 4'h8, 4'h1, 32'hCD000000, 32'h000000AB};
        vt[4] = '{0, 2'd1, 32'h203, 32'h0, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  3, 32'hABCD, 30'h80, 30'h81, 4'h0, 4'h0, 32'h0, 32'h0};
        vt[5] = '{0, 2'd2, 32'hFFFFFFFE, 32'h0, 1, 30'h3FFFFFFF, 30'h0, 32'hAABBCCDD, 32'h11223344,
                  3, 32'h3344AABB, 30'h3FFFFFFF, 30'h0, 4'h0, 4'h0, 32'h0, 32'h0};
        vt[6] = '{1, 2'd3, 32'h301, 32'h01020304, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  3, 32'h0, 30'hC0, 30'hC1, 4'hE, 4'h1, 32'h02030400, 32'h00000001};
        vt[7] = '{0, 2'd2, 32'h301, 32'h0, 0, 30'h0, 30'h0, 32'h0, 32'h0,
                  3, 32'h01020304, 30'hC0, 30'hC1, 4'h0, 4'h0, 32'h0, 32'h0};

        // Reset with a request pending: nothing may start.
        rst = 1'b1;
        bus.mem_RE = 1'b1; bus.mem_WE = 1'b0; bus.mem_by = 2'd2; bus.addr = 32'h40; bus.wdata = '0;
        tick(); tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.mem_done), 32'd0);
        check("rst_err", 32'(bus.req_err), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);
        bus.mem_RE = 1'b0;
        rst = 1'b0;
        tick();

        foreach (vt[i]) begin
            if (vt[i].pre) begin preload(vt[i].pa0, vt[i].pd0); preload(vt[i].pa1, vt[i].pd1); end
            do_access(!vt[i].wr, vt[i].wr, vt[i].by, vt[i].a, vt[i].wd, lat, rd, a0, a1, we0, we1, wd0, wd1);
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            check($sformatf("v%0d_addr0", i), 32'(a0), 32'(vt[i].a0));
            check($sformatf("v%0d_we0", i), 32'(we0), 32'(vt[i].we0));
            check($sformatf("v%0d_wd0", i), wd0, vt[i].wd0);
            if (vt[i].lat == 3) begin
                check($sformatf("v%0d_addr1", i), 32'(a1), 32'(vt[i].a1));
                check($sformatf("v%0d_we1", i), 32'(we1), 32'(vt[i].we1));
                check($sformatf("v%0d_wd1", i), wd1, vt[i].wd1);
            end
            if (vt[i].wr) ref_wr(vt[i].a, nbytes(vt[i].by), vt[i].wd);
            else          check($sformatf("v%0d_rdata", i), rd, vt[i].rd);
        end

        // Both strobes together: error pulse, no access.
        bus.mem_RE = 1'b1; bus.mem_WE = 1'b1; bus.addr = 32'h500;
        #1;
        check("clash_en_n", 32'(ram_en), 32'd0);
        tick();
        bus.mem_RE = 1'b0; bus.mem_WE = 1'b0;
        check("clash_err", 32'(bus.req_err), 32'd1);
        check("clash_busy", 32'(bus.busy), 32'd0);
        check("clash_en", 32'(ram_en), 32'd0);
        tick();
        check("clash_err_pulse", 32'(bus.req_err), 32'd0);

        // Request while busy is dropped.
        preload(30'h600, 32'hCAFEF00D);
        bus.mem_RE = 1'b1; bus.mem_by = 2'd2; bus.addr = 32'h1800;
        tick();
        bus.mem_RE = 1'b0; bus.mem_WE = 1'b1; bus.addr = 32'h1900; bus.wdata = 32'h5555AAAA;
        tick();
        check("busy_req_done", 32'(bus.mem_done), 32'd1);
        check("busy_req_rdata", bus.rdata, 32'hCAFEF00D);
        bus.mem_WE = 1'b0;
        tick();
        check("busy_req_ignored", 32'({bus.busy, ram_en}), 32'd0);

        // Reset during the second half of a split write.
        preload(30'h100, 32'h0); preload(30'h101, 32'h0);
        bus.mem_WE = 1'b1; bus.mem_by = 2'd1; bus.addr = 32'h403; bus.wdata = 32'h1234;
        tick();
        bus.mem_WE = 1'b0;
        check("rstsplit_we0", 32'(ram_we), 32'h8);
        tick();
        check("rstsplit_acc1_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        check("rstsplit_busy", 32'(bus.busy), 32'd0);
        check("rstsplit_we", 32'(ram_we), 32'd0);
        check("rstsplit_done", 32'(bus.mem_done), 32'd0);
        check("rstsplit_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 3; c++) begin tick(); if (bus.mem_done) saw_done = 1'b1; end
        check("rstsplit_no_done", 32'(saw_done), 32'd0);
        ref_wr(32'h403, 1, 32'h34);
        do_access(1, 0, 2'd1, 32'h403, 32'h0, lat, rd, a0, a1, we0, we1, wd0, wd1);
        check("rstsplit_readback", rd, ref_rd(32'h403, 2));

        // Random traffic against the byte model.
        for (int k = 0; k < 80; k++) begin
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                             : 32'h1000 + 32'($urandom_range(0, 31));
            by = 2'($urandom_range(0, 3));
            wd = $urandom;
            wr = $urandom_range(0, 1) == 1;
            re = !wr;
            n  = nbytes(by);
            exp = ref_rd(a, n);
            do_access(re, wr, by, a, wd, lat, rd, a0, a1, we0, we1, wd0, wd1);
            check("rnd_lat", 32'(lat), (32'(a[1:0]) + 32'(n) > 4) ? 32'd3 : 32'd2);
            check("rnd_addr0", 32'(a0), 32'(a >> 2));
            if (lat == 3) check("rnd_addr1", 32'(a1), 32'(30'((a >> 2) + 1)));
            if (wr) ref_wr(a, n, wd);
            else    check("rnd_rdata", rd, exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_ctrl.md
RISCV_MEM_CTRL -- requirements
Module: riscv_mem_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: mem_RE  input  1  read request pulse from control unit.
REQ-004 SHALL have port: mem_WE  input  1  write request pulse from control unit.
REQ-005 SHALL have port: mem_by  input  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
REQ-006 SHALL have port: addr  input  32  byte address of access.
REQ-007 SHALL have port: wdata  input  32  store data, LSB-aligned.
REQ-008 SHALL have port: rdata  output  32  load data, LSB-aligned, zero-filled above size.
REQ-009 SHALL have port: mem_done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port: req_err  output  1  one-cycle pulse when mem_RE and mem_WE are sampled together.
REQ-012 SHALL have ports: ram_en out 1, ram_we out 4 (byte enables), ram_addr out 30 (word address), ram_wdata out 32, ram_rdata in 32; synchronous SRAM with 1-cycle read latency.

Function
REQ-013 SHALL implement states IDLE, ACC0, ACC1, DONE.
REQ-014 SHALL sample requests only in IDLE; requests while busy SHALL be ignored.
REQ-015 SHALL, on mem_RE xor mem_WE in IDLE (cycle N), latch addr, mem_by, wdata and direction, and enter ACC0 at N+1.
REQ-016 SHALL, on mem_RE and mem_WE both high in IDLE, stay in IDLE, pulse req_err, and touch no SRAM.
REQ-017 SHALL, in ACC0, drive ram_en=1 and ram_addr=addr[31:2]; writes SHALL drive ram_we as size-mask shifted left by addr[1:0], truncated to 4 lanes, with wdata shifted by 8*addr[1:0].
REQ-018 SHALL classify an access as split when addr[1:0]+bytes exceeds 4 (half at offset 3; word at offsets 1-3); bytes never split.
REQ-019 SHALL, for non-split accesses, go ACC0 -> DONE; DONE at N+2 with mem_done=1.
REQ-020 SHALL, for split accesses, go ACC0 -> ACC1 -> DONE; ACC1 drives ram_addr=addr[31:2]+1 (modulo 2^30, 0x3FFFFFFF wraps to 0) with the remaining byte lanes; DONE at N+3.
REQ-021 SHALL, for split reads, capture the first word's upper lanes in ACC1 and merge with the second word's lower lanes in DONE.
REQ-022 SHALL present rdata in the DONE cycle and hold it until the next DONE; bits above size SHALL be zero (sign extension is the CPU's job).
REQ-023 SHALL drive ram_en=0 and ram_we=0 in IDLE and DONE; ram_we SHALL be 0 during reads.
REQ-024 SHALL return DONE -> IDLE unconditionally; back-to-back request accepted in the following IDLE cycle.

Reset
REQ-025 SHALL, while rst high, force state IDLE, rdata=0, mem_done=0, busy=0, req_err=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-026 SHALL abandon any in-flight access on reset without a mem_done; a split write reset after ACC0 leaves the first word written (documented, not an error).

Structure
REQ-027 SHALL place size codes (MEM_B=0, MEM_H=1, MEM_W=2) and state encodings in shared package riscv_mem_pkg.
REQ-028 SHALL implement lane shift/mask/merge in one combinational sub-module riscv_mem_lane; FSM and registers in riscv_mem_ctrl.

Verification
REQ-029 SHALL cover: word write addr=0x100, wdata=0xDEADBEEF -> at N+1 ram_addr=0x40, ram_we=4'b1111; mem_done at N+2.
REQ-030 SHALL cover: byte read addr=0x103, SRAM word 0x11223344 -> rdata=0x00000011 at N+2.
REQ-031 SHALL cover: half write addr=0x203, wdata=0xABCD -> ACC0 ram_we=4'b1000 data byte 0xCD at addr 0x80; ACC1 ram_we=4'b0001 byte 0xAB at addr 0x81; mem_done at N+3.
REQ-032 SHALL cover: word read addr=0xFFFFFFFE, word 0x3FFFFFFF=0xAABBCCDD, word 0=0x11223344 -> rdata=0x3344AABB at N+3 (wraps to word 0).
REQ-033 SHALL cover: mem_RE=mem_WE=1 in IDLE -> req_err pulse, ram_en stays 0, busy stays 0.
REQ-034 SHALL cover: rst asserted in ACC1 of split write -> next cycle IDLE, ram_we=0, no mem_done.
